// File: rtl/fetch_unit.sv
// HACK CPU instruction fetch: steers the program counter, reads the synchronous ROM and
// queues fetched words for decode, with a credit scheme so an in-flight read always has a slot.
module fetch_unit #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 2,
    parameter int ROM_AW = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pc,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [WIDTH-1:0]  pc_data,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data,
    input  logic              jump_valid,
    input  logic [WIDTH-1:0]  jump_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WIDTH-1:0]  instr,
    output logic [WIDTH-1:0]  instr_pc
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;

    logic [WIDTH-1:0] buf_instr [DEPTH];
    logic [WIDTH-1:0] buf_pc    [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    occ;
    logic             inflight;
    logic [WIDTH-1:0] inflight_pc;

    logic             buf_empty;
    logic             active;
    logic             pop;
    logic             pop_buf;
    logic             push;
    logic             issue;
    logic [CW:0]      committed;

    // An empty buffer presents the arriving ROM word directly, giving one-cycle fetch latency;
    // committed counts stored plus in-flight words still owed a slot after this cycle's pop.
    always_comb begin
        buf_empty   = (occ == '0);
        active      = !reset && !jump_valid;
        instr_valid = active && (!buf_empty || inflight);
        pop         = instr_valid && instr_ready;
        pop_buf     = pop && !buf_empty;
        push        = active && inflight && !(pop && buf_empty);
        committed   = {1'b0, occ} + CW1'(inflight) - CW1'(pop);
        issue       = active && (committed < CW1'(DEPTH));
    end

    always_comb begin
        pc_load  = jump_valid && !reset;
        pc_data  = jump_target;
        pc_inc   = issue;
        rom_en   = issue;
        rom_addr = pc[ROM_AW-1:0];
        instr    = '0;
        instr_pc = '0;
        if (instr_valid) begin
            if (buf_empty) begin
                instr    = rom_data;
                instr_pc = inflight_pc;
            end else begin
                instr    = buf_instr[rd_ptr];
                instr_pc = buf_pc[rd_ptr];
            end
        end
    end

    // A jump discards both the queue and the word returning this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (jump_valid) begin
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_buf) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ <= occ + CW'(push) - CW'(pop_buf);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= rom_data;
            buf_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a program counter and ROM model; a scoreboard holds the
// sequential instruction stream decode must see, restarted at every reset or jump.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } expT;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pcReg;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] pc_data;
    logic        rom_en;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        jump_valid;
    logic [15:0] jump_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    expT         expq[$];
    logic [15:0] tailPc     = 16'h0000;
    logic [15:0] jumpTgt    = 16'h0000;
    int          cyc        = 0;
    int          lastEvent  = 0;
    int          jumpCyc    = -100;
    int          resetLast  = -100;
    int          stallRun   = 0;
    int          stallLeft  = 0;
    int          idle       = 0;
    int          checks     = 0;
    int          errors     = 0;

    fetch_unit #(.WIDTH(16), .DEPTH(2), .ROM_AW(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pcReg),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .pc_data     (pc_data),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romWord(input logic [14:0] a);
        return 16'h1000 + {1'b0, a};
    endfunction

    // Program counter sharing the fetch unit's reset; jump load wins over increment.
    always @(posedge clk) begin
        if (reset)        pcReg <= 16'h0000;
        else if (pc_load) pcReg <= pc_data;
        else if (pc_inc)  pcReg <= pcReg + 16'h0001;
    end

    always @(posedge clk) begin
        if (rom_en) rom_data <= romWord(rom_addr);
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic applyStimulus();
        logic        doReset;
        logic        doJump;
        logic [15:0] tgt;
        doReset = (cyc <= 2) || (cyc == 75);
        doJump  = (cyc == 45) || (cyc == 60);
        tgt     = (cyc == 45) ? 16'h0100 : 16'hFFFF;
        if (cyc > 80 && cyc >= lastEvent + 3) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset = 1'b1;
            end else if ($urandom_range(0, 24) == 0) begin
                doJump = 1'b1;
                case ($urandom_range(0, 3))
                    0:       tgt = 16'hFFFF;
                    1:       tgt = 16'h0100;
                    2:       tgt = 16'hFFFE;
                    default: tgt = 16'($urandom);
                endcase
            end
        end
        reset       = doReset;
        jump_valid  = doJump;
        jump_target = doJump ? tgt : 16'($urandom);

        // Directed windows: free-running start, then stalls that fill the buffer before a jump/reset.
        if (cyc < 25) begin
            instr_ready = 1'b1;
        end else if ((cyc >= 40 && cyc < 45) || (cyc >= 70 && cyc < 75)) begin
            instr_ready = 1'b0;
        end else if (stallLeft > 0) begin
            instr_ready = 1'b0;
            stallLeft--;
        end else if ($urandom_range(0, 39) == 0) begin
            instr_ready = 1'b0;
            stallLeft   = 4;
        end else begin
            instr_ready = ($urandom_range(0, 3) != 0);
        end
        stallRun = instr_ready ? 0 : stallRun + 1;

        if (doReset) begin
            resetLast = cyc;
            lastEvent = cyc;
            expq.delete();
            tailPc = 16'h0000;
        end else if (doJump) begin
            jumpCyc   = cyc;
            jumpTgt   = tgt;
            lastEvent = cyc;
            expq.delete();
            tailPc = tgt;
        end
        while (expq.size() < 8) begin
            expq.push_back('{pc: tailPc, word: romWord(tailPc[14:0])});
            tailPc = tailPc + 16'h0001;
        end
    endtask

    task automatic checkOutput();
        expT head;
        if (reset) begin
            compare("reset_outputs", {28'd0, instr_valid, pc_inc, pc_load, rom_en}, 32'd0);
        end else if (jump_valid) begin
            compare("jump_ctrl", {28'd0, instr_valid, pc_load, pc_inc, rom_en}, 32'h4);
            compare("jump_data", {16'd0, pc_data}, {16'd0, jumpTgt});
        end else begin
            if (cyc == jumpCyc + 1) begin
                compare("jump_gap_valid", {31'd0, instr_valid}, 32'd0);
                compare("jump_issue", {16'd0, rom_en, rom_addr}, {16'd0, 1'b1, jumpTgt[14:0]});
            end
            if (cyc == jumpCyc + 2) compare("jump_latency_valid", {31'd0, instr_valid}, 32'd1);
            if (cyc == resetLast + 1) begin
                compare("reset_gap_valid", {31'd0, instr_valid}, 32'd0);
                compare("reset_issue", {16'd0, rom_en, rom_addr}, 32'h8000);
            end
            if (cyc == resetLast + 2) compare("reset_latency_valid", {31'd0, instr_valid}, 32'd1);
            if (rom_en) compare("rom_addr", {17'd0, rom_addr}, {17'd0, pcReg[14:0]});
            compare("pc_ctrl", {30'd0, pc_load, pc_inc}, {30'd0, 1'b0, rom_en});
            if (stallRun >= 3 && cyc >= lastEvent + 4)
                compare("stall_full", {30'd0, instr_valid, pc_inc}, 32'h2);
            if (instr_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty cycle %0d actual=pc %h required=no word", cyc, instr_pc);
                end else begin
                    head = expq[0];
                    compare("instr_pc", {16'd0, instr_pc}, {16'd0, head.pc});
                    compare("instr", {16'd0, instr}, {16'd0, head.word});
                    if (instr_ready) void'(expq.pop_front());
                end
            end
        end
        if (instr_valid) begin
            idle = 0;
        end else begin
            idle++;
            if (idle > 5) begin
                checks++;
                errors++;
                $display("[TB] FAIL progress_timeout cycle %0d actual=%0d idle cycles required=at most 5", cyc, idle);
                idle = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    initial begin
        reset       = 1'b1;
        jump_valid  = 1'b0;
        jump_target = 16'h0000;
        instr_ready = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            applyStimulus();
        end
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
